accum_unit: RTL and testbench

- Parametrised successor of the LAB3 8-bit register-plus-adder block.
- Holds a WIDTH-bit running accumulator that loads, adds or subtracts the switch operand on each KEY1 press.
- Keeps sticky carry/borrow and signed-overflow flags, plus a saturating operation counter.
- Drives flattened 7-segment buses for the accumulator and operand through the existing hex_decoder; sits directly under the board top level.

---
 rtl/accum_unit.sv | 153 +++++++++++++++
 tb/tb_accum_unit.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/accum_unit.sv
// Accumulator unit: WIDTH-bit load/add/subtract register with sticky carry/borrow and a saturating op counter.
// Optional signed-overflow flag is built only when ACCUM_SIGNED_OVF_EN is defined; otherwise OVF is tied low.

module hex_decoder (
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);
  // Active-low segments, bit 0 = a ... bit 6 = g.
  always_comb begin
    o_seg = 7'b1111111;
    case (i_nib)
      4'h0: o_seg = 7'b1000000;
      4'h1: o_seg = 7'b1111001;
      4'h2: o_seg = 7'b0100100;
      4'h3: o_seg = 7'b0110000;
      4'h4: o_seg = 7'b0011001;
      4'h5: o_seg = 7'b0010010;
      4'h6: o_seg = 7'b0000010;
      4'h7: o_seg = 7'b1111000;
      4'h8: o_seg = 7'b0000000;
      4'h9: o_seg = 7'b0010000;
      4'hA: o_seg = 7'b0001000;
      4'hB: o_seg = 7'b0000011;
      4'hC: o_seg = 7'b1000110;
      4'hD: o_seg = 7'b0100001;
      4'hE: o_seg = 7'b0000110;
      4'hF: o_seg = 7'b0001110;
      default: o_seg = 7'b1111111;
    endcase
  end
endmodule

module accum_unit #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic                     KEY1,
  input  logic                     KEY0,
  input  logic [WIDTH-1:0]         SW,
  input  logic [1:0]               OP,
  output logic [WIDTH-1:0]         ACC,
  output logic                     CARRY,
  output logic                     OVF,
  output logic                     READY,
  output logic [CNT_W-1:0]         CNT,
  output logic [7*(WIDTH/4)-1:0]   HEX_ACC,
  output logic [7*(WIDTH/4)-1:0]   HEX_B
);
  localparam int DIGITS = WIDTH / 4;

  typedef enum logic {S_EMPTY = 1'b0, S_ACTIVE = 1'b1} state_t;
  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_ADD  = 2'b01,
    OP_SUB  = 2'b10,
    OP_HOLD = 2'b11
  } op_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_acc;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;

  logic             w_do_load;
  logic             w_do_add;
  logic             w_do_sub;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_diff;
  logic             w_borrow;
  logic             w_cnt_sat;

  // In EMPTY every non-hold code acts as a load, so the first press always seeds the accumulator.
  assign w_do_load = (r_state == S_EMPTY) ? (OP != OP_HOLD) : (OP == OP_LOAD);
  assign w_do_add  = (r_state == S_ACTIVE) && (OP == OP_ADD);
  assign w_do_sub  = (r_state == S_ACTIVE) && (OP == OP_SUB);

  assign w_sum     = {1'b0, r_acc} + {1'b0, SW};
  assign w_diff    = r_acc - SW;
  assign w_borrow  = SW > r_acc;
  assign w_cnt_sat = &r_cnt;

  // State register.
  always_ff @(posedge KEY1 or negedge KEY0) begin
    if (!KEY0) r_state <= S_EMPTY;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default first so every path assigns w_state_nxt; otherwise a latch is inferred.
    w_state_nxt = r_state;
    if (r_state == S_EMPTY && OP != OP_HOLD) w_state_nxt = S_ACTIVE;
  end

  // Output logic.
  always_comb begin
    READY = (r_state == S_ACTIVE);
  end

  always_ff @(posedge KEY1 or negedge KEY0) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values of its neighbours.
    if (!KEY0) begin
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else if (w_do_load) begin
      r_acc   <= SW;
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else if (w_do_add || w_do_sub) begin
      r_acc   <= w_do_add ? w_sum[WIDTH-1:0] : w_diff;
      r_carry <= r_carry | (w_do_add ? w_sum[WIDTH] : w_borrow);
      if (!w_cnt_sat) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

`ifdef ACCUM_SIGNED_OVF_EN
  logic r_ovf;
  logic w_add_ovf;
  logic w_sub_ovf;

  assign w_add_ovf = (r_acc[WIDTH-1] == SW[WIDTH-1]) && (w_sum[WIDTH-1] != r_acc[WIDTH-1]);
  assign w_sub_ovf = (r_acc[WIDTH-1] != SW[WIDTH-1]) && (w_diff[WIDTH-1] != r_acc[WIDTH-1]);

  always_ff @(posedge KEY1 or negedge KEY0) begin
    if (!KEY0)          r_ovf <= 1'b0;
    else if (w_do_load) r_ovf <= 1'b0;
    else if (w_do_add)  r_ovf <= r_ovf | w_add_ovf;
    else if (w_do_sub)  r_ovf <= r_ovf | w_sub_ovf;
  end

  assign OVF = r_ovf;
`else
  assign OVF = 1'b0;
`endif

  assign ACC   = r_acc;
  assign CARRY = r_carry;
  assign CNT   = r_cnt;

  for (genvar k = 0; k < DIGITS; k++) begin : g_hex
    hex_decoder u_hex_acc (
      .i_nib (r_acc[4*k +: 4]),
      .o_seg (HEX_ACC[7*k +: 7])
    );
    hex_decoder u_hex_b (
      .i_nib (SW[4*k +: 4]),
      .o_seg (HEX_B[7*k +: 7])
    );
  end

endmodule

// File: tb/tb_accum_unit.sv
// Self-checking bench for accum_unit: directed scenarios plus random ops, expected state queued per edge
// and compared by an independent monitor. Honours ACCUM_SIGNED_OVF_EN for the OVF expectation.

module tb_accum_unit;
  localparam int WIDTH  = 8;
  localparam int CNT_W  = 4;
  localparam int DIGITS = WIDTH / 4;

  logic                  KEY1;
  logic                  KEY0;
  logic [WIDTH-1:0]      SW;
  logic [1:0]            OP;
  logic [WIDTH-1:0]      ACC;
  logic                  CARRY;
  logic                  OVF;
  logic                  READY;
  logic [CNT_W-1:0]      CNT;
  logic [7*DIGITS-1:0]   HEX_ACC;
  logic [7*DIGITS-1:0]   HEX_B;

  accum_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .KEY1    (KEY1),
    .KEY0    (KEY0),
    .SW      (SW),
    .OP      (OP),
    .ACC     (ACC),
    .CARRY   (CARRY),
    .OVF     (OVF),
    .READY   (READY),
    .CNT     (CNT),
    .HEX_ACC (HEX_ACC),
    .HEX_B   (HEX_B)
  );

  initial KEY1 = 1'b0;
  always #5 KEY1 = ~KEY1;

  typedef struct {
    int acc;
    bit carry;
    bit ovf;
    bit ready;
    int cnt;
    int sw;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model state, kept as plain integers.
  int m_acc, m_cnt;
  bit m_carry, m_ovf, m_active;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Active-high a..g patterns; the display itself is active-low.
  function automatic logic [6:0] seg_on(input int nib);
    logic [6:0] t [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    return t[nib & 15];
  endfunction

  function automatic logic [7*DIGITS-1:0] hex_of(input int v);
    logic [7*DIGITS-1:0] r = '0;
    for (int k = 0; k < DIGITS; k++) r[7*k +: 7] = ~seg_on((v >> (4*k)) & 15);
    return r;
  endfunction

  function automatic int to_signed(input int v);
    return (v >= (1 << (WIDTH-1))) ? v - (1 << WIDTH) : v;
  endfunction

  task automatic model_reset();
    m_acc = 0; m_cnt = 0; m_carry = 0; m_ovf = 0; m_active = 0;
  endtask

  task automatic model_apply(input int op, input int sw);
    int lim, smax, smin, sres;
    lim  = 1 << WIDTH;
    smax = (1 << (WIDTH-1)) - 1;
    smin = -(1 << (WIDTH-1));
    if (op == 3) return;
    if (!m_active || op == 0) begin
      m_acc = sw; m_carry = 0; m_ovf = 0; m_cnt = 0; m_active = 1;
    end else if (op == 1) begin
      sres = to_signed(m_acc) + to_signed(sw);
      if (m_acc + sw >= lim) m_carry = 1;
      if (sres > smax || sres < smin) m_ovf = 1;
      m_acc = (m_acc + sw) % lim;
      m_cnt = (m_cnt + 1 > (1 << CNT_W) - 1) ? (1 << CNT_W) - 1 : m_cnt + 1;
    end else begin
      sres = to_signed(m_acc) - to_signed(sw);
      if (sw > m_acc) m_carry = 1;
      if (sres > smax || sres < smin) m_ovf = 1;
      m_acc = (m_acc - sw + lim) % lim;
      m_cnt = (m_cnt + 1 > (1 << CNT_W) - 1) ? (1 << CNT_W) - 1 : m_cnt + 1;
    end
  endtask

  // Drive one operation for the next rising edge and queue the state expected after it.
  task automatic do_op(input int op, input int sw);
    exp_t e;
    @(negedge KEY1);
    #1;
    SW = WIDTH'(sw);
    OP = 2'(op);
    model_apply(op, sw);
    e.acc = m_acc; e.carry = m_carry; e.ready = m_active; e.cnt = m_cnt; e.sw = sw;
`ifdef ACCUM_SIGNED_OVF_EN
    e.ovf = m_ovf;
`else
    e.ovf = 1'b0;
`endif
    sb.push_back(e);
    @(posedge KEY1);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_acc"},   32'(ACC),   32'h0);
    check({tag, "_carry"}, 32'(CARRY), 32'h0);
    check({tag, "_ovf"},   32'(OVF),   32'h0);
    check({tag, "_cnt"},   32'(CNT),   32'h0);
    check({tag, "_ready"}, 32'(READY), 32'h0);
  endtask

  // Assert reset between edges, check without any KEY1 edge, hold across one edge, then release.
  task automatic reset_mid();
    @(negedge KEY1);
    #1;
    OP   = 2'b11;
    KEY0 = 1'b0;
    model_reset();
    #1;
    check_reset_state("rst_mid");
    @(negedge KEY1);
    #1;
    KEY0 = 1'b1;
  endtask

  // Monitor: after every rising edge, compare the DUT against everything queued for it.
  initial begin
    exp_t e;
    forever begin
      @(posedge KEY1);
      #2;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        check("acc",     32'(ACC),     32'(e.acc));
        check("carry",   32'(CARRY),   32'(e.carry));
        check("ovf",     32'(OVF),     32'(e.ovf));
        check("ready",   32'(READY),   32'(e.ready));
        check("cnt",     32'(CNT),     32'(e.cnt));
        check("hex_acc", 32'(HEX_ACC), 32'(hex_of(e.acc)));
        check("hex_b",   32'(HEX_B),   32'(hex_of(e.sw)));
      end
    end
  end

  initial begin
    int guard;
    KEY0 = 1'b0;
    SW   = '0;
    OP   = 2'b11;
    model_reset();
    #3;
    check_reset_state("rst_init");
    @(negedge KEY1);
    #1;
    KEY0 = 1'b1;

    // EMPTY: hold does nothing, add acts as load.
    do_op(3, 8'h3C);
    do_op(1, 8'h3C);

    // Unsigned carry, sticky.
    do_op(0, 8'hF0);
    do_op(1, 8'h20);
    do_op(1, 8'h01);

    // Borrow, cleared by load, equal subtract gives zero with no borrow.
    do_op(0, 8'h05);
    do_op(2, 8'h07);
    do_op(0, 8'h07);
    do_op(2, 8'h07);

    // Signed overflow without unsigned carry.
    do_op(0, 8'h70);
    do_op(1, 8'h20);
    do_op(3, 8'hAA);

    // Counter saturation: 20 increments from zero.
    do_op(0, 8'h00);
    for (int i = 0; i < 20; i++) do_op(1, 8'h01);

    // HEX_B follows SW with no clock edge.
    @(negedge KEY1);
    #1;
    SW = 8'hB7;
    #1;
    check("hex_b_comb", 32'(HEX_B), 32'(hex_of(8'hB7)));
    check("acc_no_edge", 32'(ACC), 32'(m_acc));

    // Reset while active.
    do_op(0, 8'h55);
    reset_mid();

    // Randomised operations with occasional resets.
    for (int i = 0; i < 250; i++) begin
      int op, sw;
      op = int'($urandom_range(0, 3));
      case ($urandom_range(0, 7))
        0:       sw = 0;
        1:       sw = m_acc;
        2:       sw = (1 << WIDTH) - 1;
        default: sw = int'($urandom_range(0, (1 << WIDTH) - 1));
      endcase
      if (i % 97 == 96) reset_mid();
      else do_op(op, sw);
    end

    // Drain the scoreboard with a bounded wait.
    guard = 0;
    while (sb.size() > 0 && guard < 20) begin
      @(posedge KEY1);
      guard++;
    end
    #3;
    check("scoreboard_drained", 32'(sb.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
